// File: rtl/vec_mac_unit.sv
// Multi-cycle signed packed-vector dot-product / MAC unit.
// One lane per cycle into a non-wrapping partial sum, then sat/wrap to ACC_W.
module vec_mac_unit #(
   parameter int LANES  = 2,
   parameter int ELEM_W = 16,
   parameter int ACC_W  = 32,
   parameter int SAT    = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                op,
   input  logic [LANES*ELEM_W-1:0]   a,
   input  logic [LANES*ELEM_W-1:0]   b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ACC_W-1:0]          result,
   output logic                      overflow,
   output logic                      busy
);

   localparam int LG     = (LANES > 1) ? $clog2(LANES) : 0;
   localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PSUM_W = 2*ELEM_W + LG + 1;
   localparam int FULL_W = ((PSUM_W > ACC_W) ? PSUM_W : ACC_W) + 1;
   localparam int VEC_W  = LANES*ELEM_W;

   localparam logic [1:0] OP_DOT    = 2'b00;
   localparam logic [1:0] OP_DOTACC = 2'b01;
   localparam logic [1:0] OP_RELU   = 2'b10;
   localparam logic [1:0] OP_CLR    = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                    state;
   logic [VEC_W-1:0]          a_q;
   logic [VEC_W-1:0]          b_q;
   logic [1:0]                op_q;
   logic [CNT_W-1:0]          cnt;
   logic signed [PSUM_W-1:0]  psum;
   logic signed [ACC_W-1:0]   acc;

   logic signed [ELEM_W-1:0]   a_lane;
   logic signed [ELEM_W-1:0]   b_lane;
   logic signed [2*ELEM_W-1:0] prod;
   logic signed [PSUM_W-1:0]   psum_next;
   logic signed [FULL_W-1:0]   ps_ext;
   logic signed [FULL_W-1:0]   acc_ext;
   logic signed [FULL_W-1:0]   full;
   logic [FULL_W-ACC_W:0]      upper;
   logic                       ovf;
   logic [ACC_W-1:0]           sat_val;
   logic [ACC_W-1:0]           f_val;
   logic                       relu_neg;
   logic [ACC_W-1:0]           res_next;
   logic                       ovf_next;
   logic                       last;

   assign in_ready = !reset && (state == IDLE);
   assign busy     = (state != IDLE);

   always_comb begin
      a_lane    = a_q[int'(cnt)*ELEM_W +: ELEM_W];
      b_lane    = b_q[int'(cnt)*ELEM_W +: ELEM_W];
      prod      = a_lane * b_lane;
      psum_next = psum + {{(PSUM_W-2*ELEM_W){prod[2*ELEM_W-1]}}, prod};
      ps_ext    = {{(FULL_W-PSUM_W){psum_next[PSUM_W-1]}}, psum_next};
      acc_ext   = {{(FULL_W-ACC_W){acc[ACC_W-1]}}, acc};
      full      = (op_q == OP_DOTACC) ? acc_ext + ps_ext : ps_ext;
      // In range iff every bit from the ACC_W sign bit upward agrees.
      upper     = full[FULL_W-1:ACC_W-1];
      ovf       = !((&upper) || !(|upper));
      sat_val   = full[FULL_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
      f_val     = ((SAT != 0) && ovf) ? sat_val : full[ACC_W-1:0];
      relu_neg  = (op_q == OP_RELU) && psum_next[PSUM_W-1];
      res_next  = relu_neg ? '0 : f_val;
      ovf_next  = relu_neg ? 1'b0 : ovf;
      last      = (cnt == CNT_W'(LANES-1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_DOT;
         cnt       <= '0;
         psum      <= '0;
         acc       <= '0;
         result    <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  op_q  <= op;
                  psum  <= '0;
                  cnt   <= '0;
                  state <= (op == OP_CLR) ? DONE : RUN;
               end
            end
            RUN: begin
               psum <= psum_next;
               if (last) begin
                  result    <= res_next;
                  overflow  <= ovf_next;
                  out_valid <= 1'b1;
                  if (op_q == OP_DOTACC) acc <= res_next;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               // CLR enters DONE without a result; publish it one edge later.
               if (!out_valid) begin
                  result    <= '0;
                  overflow  <= 1'b0;
                  acc       <= '0;
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_mac_unit.sv
// Bench for vec_mac_unit: LANES=2/SAT=1 and LANES=4/SAT=0 instances
// driven in lockstep, checked by vector table, hand sequences and a model.
module tb_vec_mac_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [1:0]  op;
   logic [63:0] a;
   logic [63:0] b;

   logic        in_ready2, out_valid2, ovf2, busy2;
   logic [31:0] res2;
   logic        in_ready4, out_valid4, ovf4, busy4;
   logic [31:0] res4;

   int total = 0;
   int bad   = 0;

   longint      acc2_m, acc4_m;
   logic [31:0] er2, er4;
   logic        eo2, eo4;
   logic [1:0]  cur_op;

   always #5 clk = ~clk;

   vec_mac_unit #(.LANES(2), .ELEM_W(16), .ACC_W(32), .SAT(1)) u2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .op(op), .a(a[31:0]), .b(b[31:0]), .out_valid(out_valid2),
      .out_ready(out_ready), .result(res2), .overflow(ovf2), .busy(busy2));

   vec_mac_unit #(.LANES(4), .ELEM_W(16), .ACC_W(32), .SAT(0)) u4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
      .op(op), .a(a), .b(b), .out_valid(out_valid4),
      .out_ready(out_ready), .result(res4), .overflow(ovf4), .busy(busy4));

   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [31:0] r;
      logic        ov;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model(input int lanes, input bit sat, input logic [1:0] o,
                        input logic [63:0] av, input logic [63:0] bv,
                        inout longint acc, output logic [31:0] r,
                        output logic ov);
      longint dot = 0;
      longint v;
      for (int i = 0; i < lanes; i++)
         dot += longint'($signed(av[i*16 +: 16])) *
                longint'($signed(bv[i*16 +: 16]));
      if (o == 2'b11) begin
         acc = 0; r = '0; ov = 1'b0;
         return;
      end
      v  = (o == 2'b01) ? acc + dot : dot;
      ov = (v > 64'sd2147483647) || (v < -64'sd2147483648);
      if (ov && sat) r = (v > 0) ? 32'h7fffffff : 32'h80000000;
      else r = v[31:0];
      if (o == 2'b10 && dot < 0) begin
         r = '0; ov = 1'b0;
      end
      if (o == 2'b01) acc = longint'($signed(r));
   endtask

   task automatic start(input logic [1:0] o, input logic [63:0] av,
                        input logic [63:0] bv);
      op = o; a = av; b = bv; cur_op = o;
      chk("in_ready2 idle", in_ready2, 1);
      chk("in_ready4 idle", in_ready4, 1);
      model(2, 1'b1, o, av, bv, acc2_m, er2, eo2);
      model(4, 1'b0, o, av, bv, acc4_m, er4, eo4);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int l2 = 0;
      int l4 = 0;
      for (int k = 1; k <= 8 && (l2 == 0 || l4 == 0); k++) begin
         @(posedge clk); #1;
         if (out_valid2 && l2 == 0) l2 = k;
         if (out_valid4 && l4 == 0) l4 = k;
      end
      chk("latency2", l2, (cur_op == 2'b11) ? 1 : 2);
      chk("latency4", l4, (cur_op == 2'b11) ? 1 : 4);
   endtask

   task automatic check_model(input string tag);
      chk({tag, " res2 model"}, res2, er2);
      chk({tag, " ovf2 model"}, ovf2, eo2);
      chk({tag, " res4 model"}, res4, er4);
      chk({tag, " ovf4 model"}, ovf4, eo4);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("out_valid2 cleared", out_valid2, 0);
      chk("out_valid4 cleared", out_valid4, 0);
      chk("in_ready2 after hs", in_ready2, 1);
      chk("in_ready4 after hs", in_ready4, 1);
   endtask

   task automatic txn(input string tag, input logic [1:0] o,
                      input logic [63:0] av, input logic [63:0] bv);
      start(o, av, bv);
      wait_done();
      check_model(tag);
      handshake();
   endtask

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{2'b00, 64'h0003FFFE, 64'h00040005, 32'h00000002, 1'b0};
      tbl[1]  = '{2'b00, 64'h80008000, 64'h80008000, 32'h7FFFFFFF, 1'b1};
      tbl[2]  = '{2'b10, 64'h00010002, 64'hFFFFFFFF, 32'h00000000, 1'b0};
      tbl[3]  = '{2'b10, 64'h00010002, 64'h00010001, 32'h00000003, 1'b0};
      tbl[4]  = '{2'b11, 64'h12345678, 64'h9ABCDEF0, 32'h00000000, 1'b0};
      tbl[5]  = '{2'b01, 64'h0003FFFE, 64'h00040005, 32'h00000002, 1'b0};
      tbl[6]  = '{2'b01, 64'h0003FFFE, 64'h00040005, 32'h00000004, 1'b0};
      tbl[7]  = '{2'b00, 64'h0000000A, 64'h0000000A, 32'h00000064, 1'b0};
      tbl[8]  = '{2'b01, 64'h0003FFFE, 64'h00040005, 32'h00000006, 1'b0};
      tbl[9]  = '{2'b01, 64'h80008000, 64'h80008000, 32'h7FFFFFFF, 1'b1};
      tbl[10] = '{2'b11, 64'h0, 64'h0, 32'h00000000, 1'b0};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op = 2'b00; a = '0; b = '0; cur_op = 2'b00;
      acc2_m = 0; acc4_m = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset result2", res2, 0);
      chk("reset ovf2", ovf2, 0);
      chk("reset out_valid2", out_valid2, 0);
      chk("reset busy2", busy2, 0);
      chk("reset in_ready2", in_ready2, 0);
      chk("reset out_valid4", out_valid4, 0);
      reset = 1'b0;
      #1;
      chk("in_ready2 post reset", in_ready2, 1);
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         start(tbl[i].op, tbl[i].a, tbl[i].b);
         wait_done();
         chk($sformatf("vec%0d result2", i), res2, tbl[i].r);
         chk($sformatf("vec%0d ovf2", i), ovf2, tbl[i].ov);
         chk($sformatf("vec%0d result4", i), res4, er4);
         chk($sformatf("vec%0d ovf4", i), ovf4, eo4);
         handshake();
      end

      // LANES=4 SAT=0 wraps the same 2^31 dot product
      txn("wrap", 2'b00, 64'h80008000, 64'h80008000);
      chk("wrap result4", res4, 32'h80000000);
      chk("wrap ovf4", ovf4, 1);

      // Backpressure with a competing request held on the input
      start(2'b00, 64'h0003FFFE, 64'h00040005);
      wait_done();
      op = 2'b01; a = 64'h0000000A; b = 64'h0000000A; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp in_ready2", in_ready2, 0);
         chk("bp in_ready4", in_ready4, 0);
         chk("bp out_valid2", out_valid2, 1);
         chk("bp result2 held", res2, 32'h2);
         chk("bp result4 held", res4, 32'h2);
      end
      handshake();
      start(2'b01, 64'h0000000A, 64'h0000000A);
      wait_done();
      chk("bp new result2", res2, 32'd100);
      check_model("bp");
      handshake();

      // Reset two cycles into a DOTACC on the 4-lane unit
      start(2'b01, 64'h0001000100010001, 64'h0001000100010001);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst out_valid2", out_valid2, 0);
      chk("rst out_valid4", out_valid4, 0);
      chk("rst busy2", busy2, 0);
      chk("rst busy4", busy4, 0);
      acc2_m = 0; acc4_m = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      txn("post rst", 2'b01, 64'h00000005, 64'h00000001);
      chk("post rst result4", res4, 32'd5);
      chk("post rst result2", res2, 32'd5);

      for (int i = 0; i < 60; i++) begin
         logic [1:0]  ro;
         logic [63:0] ra, rb;
         ro = 2'($urandom_range(0, 3));
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) begin
            ra = ra & 64'h80FF80FF80FF80FF;
            rb = rb & 64'h80FF80FF80FF80FF;
         end
         txn($sformatf("rnd%0d", i), ro, ra, rb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
